// File: rtl/adder_sweep_checker.sv
// Exhaustive self-test driver and checker for a WIDTH-bit add/subtract block.
// Sweeps every (Cin, a, b) vector and holds each one for SETTLE cycles.
// It then compares the adder outputs against a (WIDTH+1)-bit reference.
// It counts mismatching vectors and latches the first failing vector.
module adder_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     in_a,
  output logic [WIDTH-1:0]     in_b,
  output logic                 Cin,
  input  logic [WIDTH-1:0]     Result,
  input  logic                 Carry,
  input  logic                 Zero,
  input  logic                 Overflow,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin,
  output logic [3:0]           fail_mask
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t state, state_next;

  // Vector index packed as {Cin, a, b}: incrementing it walks b innermost,
  // then a, then Cin outermost.
  logic [VW-1:0]    vec;
  logic [CW-1:0]    settle_cnt;
  logic             load;
  logic             advance;
  logic             last_vec;

  logic [WIDTH:0]   k;
  logic             exp_zero;
  logic             exp_ovf;
  logic [3:0]       mask;
  logic             check_fail;
  logic [EW-1:0]    err_next;

  assign {Cin, in_a, in_b} = vec;
  assign last_vec = (vec == '1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and sweep control strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (settle_cnt == SETTLE_LAST) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (last_vec) begin
          state_next = ST_DONE;
        end else begin
          advance    = 1'b1;
          state_next = ST_WAIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reference model; subtract is a + ~b + 1, so Carry is carry-out, not borrow.
  always_comb begin
    k          = {1'b0, in_a} + {1'b0, in_b ^ {WIDTH{Cin}}} + {{WIDTH{1'b0}}, Cin};
    exp_zero   = (k[WIDTH-1:0] == '0);
    exp_ovf    = (in_a[WIDTH-1] == (in_b[WIDTH-1] ^ Cin)) &&
                 (k[WIDTH-1] != in_a[WIDTH-1]);
    mask       = {Result != k[WIDTH-1:0], Carry != k[WIDTH],
                  Zero != exp_zero, Overflow != exp_ovf};
    check_fail = (state == ST_CHECK) && (mask != 4'b0000);
    err_next   = err_count + {{(EW-1){1'b0}}, check_fail};
  end

  // Sweep datapath: vector, settle counter, error tally and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_mask  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (load) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      fail_mask  <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (state == ST_WAIT) begin
        if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
        else                           settle_cnt <= settle_cnt + 1'b1;
      end
      if (state == ST_CHECK) begin
        err_count <= err_next;
        // An empty tally means this is the first failure of the sweep.
        if (check_fail && (err_count == '0)) begin
          fail_a    <= in_a;
          fail_b    <= in_b;
          fail_cin  <= Cin;
          fail_mask <= mask;
        end
        if (advance) vec <= vec + 1'b1;
        if (state_next == ST_DONE) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: a behavioural adder with injectable faults
// feeds the checker, and a vector-walking reference predicts its verdict.
module tb_adder_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] in_a, in_b;
  logic       Cin;
  logic [3:0] Result;
  logic       Carry, Zero, Overflow;
  logic       busy, done, pass;
  logic [9:0] err_count;
  logic [3:0] fail_a, fail_b;
  logic       fail_cin;
  logic [3:0] fail_mask;

  int n_checks = 0;
  int n_pass   = 0;

  // Fault controls for the behavioural adder.
  logic       f_c0, f_z0, f_o0;
  logic [3:0] flip [512];

  always #5 clk = ~clk;

  adder_sweep_checker #(.WIDTH(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_a(in_a), .in_b(in_b), .Cin(Cin),
    .Result(Result), .Carry(Carry), .Zero(Zero), .Overflow(Overflow),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_cin(fail_cin), .fail_mask(fail_mask)
  );

  // Ideal adder from signed/unsigned integer arithmetic: {res[3:0], c, z, o}.
  function automatic logic [6:0] ideal_out(input int a, input int b, input int c);
    int s, sa, sb, sv;
    logic [3:0] r;
    logic car, ovf;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (c == 0) begin
      s = a + b; sv = sa + sb; car = (s > 15);
    end else begin
      s = a - b; sv = sa - sb; car = (a >= b);
    end
    r   = 4'(s & 15);
    ovf = (sv > 7) || (sv < -8);
    return {r, car, (r == 4'd0), ovf};
  endfunction

  function automatic logic [6:0] faulty_out(input int a, input int b, input int c);
    logic [6:0] v;
    logic [3:0] f;
    v = ideal_out(a, b, c);
    if (f_c0) v[2] = 1'b0;
    if (f_z0) v[1] = 1'b0;
    if (f_o0) v[0] = 1'b0;
    f = flip[c*256 + a*16 + b];
    v[3] = v[3] ^ f[3];
    v[2] = v[2] ^ f[2];
    v[1] = v[1] ^ f[1];
    v[0] = v[0] ^ f[0];
    return v;
  endfunction

  // Behavioural adder under test.
  always_comb begin
    {Result, Carry, Zero, Overflow} = faulty_out(int'(in_a), int'(in_b), int'(Cin));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Predict err_count and the first failure by walking the sweep order.
  task automatic predict(output int err, output int fa, output int fb,
                         output int fc, output int fm);
    logic [6:0] g, v;
    int m;
    err = 0; fa = 0; fb = 0; fc = 0; fm = 0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          g = ideal_out(a, b, c);
          v = faulty_out(a, b, c);
          m = {28'd0, v[6:3] != g[6:3], v[2] != g[2], v[1] != g[1], v[0] != g[0]};
          if (m != 0) begin
            if (err == 0) begin fa = a; fb = b; fc = c; fm = m; end
            err++;
          end
        end
  endtask

  task automatic clear_faults();
    f_c0 = 1'b0; f_z0 = 1'b0; f_o0 = 1'b0;
    for (int i = 0; i < 512; i++) flip[i] = 4'd0;
  endtask

  // Drive start for one edge and check the immediate effect of the start edge.
  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_err_clear"}, 64'(err_count), 64'd0);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
    end
    if (!done) check({tag, "_done_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic run_sweep(input string tag);
    int err, fa, fb, fc, fm, cyc;
    predict(err, fa, fb, fc, fm);
    pulse_start(tag);
    wait_done(tag, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd1536);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'(err));
    check({tag, "_pass"}, 64'(pass), 64'(err == 0));
    check({tag, "_first"}, 64'({fail_a, fail_b, fail_cin, fail_mask}),
          64'({4'(fa), 4'(fb), 1'(fc), 4'(fm)}));
  endtask

  initial begin
    int cyc;
    clear_faults();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({in_a, in_b, Cin, busy, done, pass, err_count, fail_a, fail_b, fail_cin, fail_mask}),
          64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep("golden");
    check("golden_mask", 64'(fail_mask), 64'd0);

    f_c0 = 1'b1;
    run_sweep("carry0");
    check("carry0_count_const", 64'(err_count), 64'd256);
    check("carry0_first_const", 64'({fail_a, fail_b, fail_cin, fail_mask}),
          64'({4'd1, 4'd15, 1'b0, 4'b0100}));
    clear_faults();

    f_o0 = 1'b1;
    run_sweep("ovf0");
    check("ovf0_count_const", 64'(err_count), 64'd128);
    check("ovf0_first_const", 64'({fail_a, fail_b, fail_cin, fail_mask}),
          64'({4'd1, 4'd7, 1'b0, 4'b0001}));
    clear_faults();

    f_z0 = 1'b1;
    run_sweep("zero0");
    check("zero0_count_const", 64'(err_count), 64'd32);
    check("zero0_first_const", 64'({fail_a, fail_b, fail_cin, fail_mask}),
          64'({4'd0, 4'd0, 1'b0, 4'b0010}));
    clear_faults();

    for (int it = 0; it < 3; it++) begin
      int n;
      clear_faults();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) flip[$urandom_range(0, 511)] = 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_sweep("random");
    end
    clear_faults();

    // Reset in the middle of a faulty sweep.
    f_c0 = 1'b1;
    pulse_start("midreset");
    repeat (699) @(posedge clk);
    #1;
    check("midreset_partial_err", 64'(err_count != 0), 64'd1);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs",
          64'({in_a, in_b, Cin, busy, done, pass, err_count, fail_a, fail_b, fail_cin, fail_mask}),
          64'd0);
    @(negedge clk) rst_n = 1'b1;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check("midreset_idle", 64'({busy, done}), 64'd0);
    run_sweep("after_reset");

    // start held high for the whole sweep must not restart it.
    f_z0 = 1'b1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    wait_done("held", cyc);
    start = 1'b0;
    check("held_latency", 64'(cyc), 64'd1536);
    check("held_err", 64'(err_count), 64'd32);
    repeat (3) @(negedge clk);
    check("held_done_stays", 64'(done), 64'd1);
    run_sweep("rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
